// File: rtl/uart_transmitter.sv
// UART transmit serializer paced by a 16x oversample Tick: start, data LSB first, optional parity, stop.
// Optional parity bit is compiled in with the TX_PARITY_EN macro.
module uart_transmitter #(
  parameter int DATA_BITS      = 8,
  parameter int OVERSAMPLE     = 16,
  parameter int STOP_BIT_TICKS = 16,
  parameter int PARITY_ODD     = 0
) (
  input  logic                 Clock,
  input  logic                 ResetN,
  input  logic                 Tick,
  input  logic                 TxStart,
  input  logic [DATA_BITS-1:0] TxData,
  output logic                 Tx,
  output logic                 TxBusy,
  output logic                 TxDone
);

  localparam int MAX_TICKS = (STOP_BIT_TICKS > OVERSAMPLE) ? STOP_BIT_TICKS : OVERSAMPLE;
  localparam int TW        = (MAX_TICKS > 2) ? $clog2(MAX_TICKS) : 1;
  localparam int DW        = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [TW-1:0] BIT_LAST  = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] STOP_LAST = TW'(STOP_BIT_TICKS - 1);
  localparam logic [DW-1:0] DATA_LAST = DW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_e;

  state_e               state_q, state_d;
  logic [TW-1:0]        tickCnt_q, tickCnt_d;
  logic [DW-1:0]        dataCnt_q, dataCnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 bitEnd;
`ifdef TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  assign bitEnd = Tick && (tickCnt_q == ((state_q == STOP) ? STOP_LAST : BIT_LAST));

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q   <= IDLE;
      tickCnt_q <= '0;
      dataCnt_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      tickCnt_q <= tickCnt_d;
      dataCnt_q <= dataCnt_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  // Tick count advances on every Tick in a frame; each bit end clears it for the next state.
  always_comb begin
    state_d   = state_q;
    tickCnt_d = tickCnt_q;
    dataCnt_d = dataCnt_q;
    shift_d   = shift_q;
    done_d    = 1'b0;
`ifdef TX_PARITY_EN
    parity_d  = parity_q;
`endif
    if (state_q != IDLE && Tick) begin
      tickCnt_d = tickCnt_q + 1'b1;
    end
    unique case (state_q)
      IDLE: begin
        if (TxStart) begin
          shift_d   = TxData;
          state_d   = START;
          tickCnt_d = '0;
          dataCnt_d = '0;
`ifdef TX_PARITY_EN
          parity_d  = (^TxData) ^ (PARITY_ODD != 0);
`endif
        end
      end
      START: begin
        if (bitEnd) begin
          state_d   = DATA;
          tickCnt_d = '0;
          dataCnt_d = '0;
        end
      end
      DATA: begin
        if (bitEnd) begin
          shift_d   = shift_q >> 1;
          tickCnt_d = '0;
          if (dataCnt_q == DATA_LAST) begin
`ifdef TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            dataCnt_d = dataCnt_q + 1'b1;
          end
        end
      end
`ifdef TX_PARITY_EN
      PARITY: begin
        if (bitEnd) begin
          state_d   = STOP;
          tickCnt_d = '0;
        end
      end
`endif
      STOP: begin
        if (bitEnd) begin
          state_d   = IDLE;
          tickCnt_d = '0;
          done_d    = 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        tickCnt_d = '0;
      end
    endcase
  end

  // Line level is derived from the next state so Tx changes on the same edge as the state.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_d != IDLE);
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef TX_PARITY_EN
      PARITY:  tx_d = parity_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  assign Tx     = tx_q;
  assign TxBusy = busy_q;
  assign TxDone = done_q;

endmodule
